// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with input synchroniser,
// start-bit glitch rejection, parity/framing checks and a small
// first-word-fall-through output FIFO with ready/valid handshake.
//
// Ports:
//   i_clock       system clock, rising edge
//   i_reset_n     synchronous active-low reset
//   i_rx_uart     asynchronous serial input, idle high
//   o_rx_valid    FIFO head entry valid
//   i_rx_ready    consumer accepts head entry (pop on valid && ready)
//   o_rx_data     head entry data
//   o_parity_err  head entry parity error
//   o_frame_err   head entry stop-bit error
//   o_overflow    one-cycle pulse when a completed frame is dropped (FIFO full)
//   o_busy        receiver is not idle
//   o_fifo_count  number of occupied FIFO entries
module uart_rx_param #(
  parameter int clks_per_bit = 217,
  parameter int data_bits    = 8,
  parameter int parity_mode  = 0,
  parameter int stop_bits    = 1,
  parameter int fifo_depth   = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic                          i_rx_uart,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic [data_bits-1:0]          o_rx_data,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overflow,
  output logic                          o_busy,
  output logic [$clog2(fifo_depth):0]   o_fifo_count
);

  localparam int CNTW  = $clog2(clks_per_bit);
  localparam int IDXW  = $clog2(data_bits + 1);
  localparam int PTRW  = $clog2(fifo_depth);
  localparam int CNTFW = PTRW + 1;
  localparam int ENTW  = data_bits + 2;

  localparam logic [CNTW-1:0]  CNT_LAST  = CNTW'(clks_per_bit - 1);
  localparam logic [CNTW-1:0]  CNT_HALF  = CNTW'(clks_per_bit / 2 - 1);
  localparam logic [IDXW-1:0]  IDX_LAST  = IDXW'(data_bits - 1);
  localparam logic             STOP_LAST = (stop_bits == 2);
  localparam logic [CNTFW-1:0] FIFO_FULL = CNTFW'(fifo_depth);
  localparam logic [CNTFW-1:0] FIFO_ONE  = CNTFW'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic                 sync1_q, sync2_q;
  logic                 rxS;
  logic [2:0]           state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic                 parErr_q, parErr_d;
  logic                 frameErr_q, frameErr_d;
  logic                 stopIdx_q, stopIdx_d;
  logic                 stopDone_q, stopDone_d;
  logic                 push;

  logic [ENTW-1:0]      mem_q [fifo_depth];
  logic [PTRW-1:0]      wrPtr_q, wrPtr_d;
  logic [PTRW-1:0]      rdPtr_q, rdPtr_d;
  logic [PTRW-1:0]      rdNext;
  logic [CNTFW-1:0]     count_q, count_d;
  logic [ENTW-1:0]      head_q, head_d;
  logic                 ovf_q, ovf_d;
  logic [ENTW-1:0]      newEntry;
  logic                 valid, pop, full, pushAcc;

  assign rxS = sync2_q;

  // Receive FSM. STOP lingers one extra cycle after the final stop sample
  // (stopDone_q) so the push lands exactly one edge after that sample.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    parErr_d   = parErr_q;
    frameErr_d = frameErr_q;
    stopIdx_d  = stopIdx_q;
    stopDone_d = stopDone_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxS) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rxS) begin
            state_d    = S_DATA;
            idx_d      = '0;
            parErr_d   = 1'b0;
            frameErr_d = 1'b0;
            stopIdx_d  = 1'b0;
            stopDone_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxS, shift_q[data_bits-1:1]};
          idx_d   = idx_q + IDXW'(1);
          if (idx_q == IDX_LAST) begin
            state_d = (parity_mode != 0) ? S_PARITY : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          parErr_d = ((^shift_q) ^ rxS) != (parity_mode == 2);
          state_d  = S_STOP;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_STOP: begin
        if (stopDone_q) begin
          push       = 1'b1;
          stopDone_d = 1'b0;
          state_d    = frameErr_q ? S_WAIT_IDLE : S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rxS) begin
            frameErr_d = 1'b1;
          end
          if (stopIdx_q == STOP_LAST) begin
            stopDone_d = 1'b1;
          end else begin
            stopIdx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_WAIT_IDLE: begin
        // Hold off while the line is held low (break) so it cannot retrigger.
        if (rxS) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control. The head is kept in its own register so the outputs hold
  // their last value once the FIFO drains instead of following stale memory.
  assign newEntry = {shift_q, parErr_q, frameErr_q};
  assign valid    = (count_q != '0);
  assign pop      = valid && i_rx_ready;
  assign full     = (count_q == FIFO_FULL);
  assign pushAcc  = push && (!full || pop);
  assign rdNext   = rdPtr_q + PTRW'(1);

  always_comb begin
    wrPtr_d = pushAcc ? wrPtr_q + PTRW'(1) : wrPtr_q;
    rdPtr_d = pop ? rdNext : rdPtr_q;
    ovf_d   = push && full && !pop;
    count_d = count_q;
    if (pushAcc && !pop) begin
      count_d = count_q + CNTFW'(1);
    end else if (!pushAcc && pop) begin
      count_d = count_q - CNTFW'(1);
    end
    head_d = head_q;
    if (pop) begin
      if (count_q > FIFO_ONE) begin
        head_d = mem_q[rdNext];
      end else if (pushAcc) begin
        head_d = newEntry;
      end
    end else if (pushAcc && !valid) begin
      head_d = newEntry;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      parErr_q   <= 1'b0;
      frameErr_q <= 1'b0;
      stopIdx_q  <= 1'b0;
      stopDone_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      head_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= i_rx_uart;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      parErr_q   <= parErr_d;
      frameErr_q <= frameErr_d;
      stopIdx_q  <= stopIdx_d;
      stopDone_q <= stopDone_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset_n && pushAcc) begin
      mem_q[wrPtr_q] <= newEntry;
    end
  end

  assign o_rx_valid   = valid;
  assign o_rx_data    = head_q[ENTW-1:2];
  assign o_parity_err = head_q[1];
  assign o_frame_err  = head_q[0];
  assign o_overflow   = ovf_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: self-checking bench for uart_rx_param.
// Three receiver setups share one clock: the default 8N1 receiver, an
// even/odd parity pair fed from the same line, and a two-stop-bit receiver.
// Expected values come from the frame contents (bit counts, constants).
module tb_uart_rx_param;

  localparam int CPB0 = 217;
  localparam int CPBS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rx0, rdy0, valid0, perr0, ferr0, ovf0, busy0;
  logic [7:0] data0;
  logic [2:0] cnt0;

  logic       rstP, rxP, rdyP;
  logic       validE, perrE, ferrE, ovfE, busyE;
  logic       validO, perrO, ferrO, ovfO, busyO;
  logic [7:0] dataE, dataO;
  logic [2:0] cntE, cntO;

  logic       rst2, rx2, rdy2, valid2, perr2, ferr2, ovf2, busy2;
  logic [7:0] data2;
  logic [2:0] cnt2;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [9:0] popQ0[$];
  int         ovfCnt0 = 0;

  uart_rx_param dut0 (
    .i_clock(clk), .i_reset_n(rst0), .i_rx_uart(rx0), .o_rx_valid(valid0),
    .i_rx_ready(rdy0), .o_rx_data(data0), .o_parity_err(perr0),
    .o_frame_err(ferr0), .o_overflow(ovf0), .o_busy(busy0), .o_fifo_count(cnt0)
  );

  uart_rx_param #(.clks_per_bit(CPBS), .parity_mode(1)) dutE (
    .i_clock(clk), .i_reset_n(rstP), .i_rx_uart(rxP), .o_rx_valid(validE),
    .i_rx_ready(rdyP), .o_rx_data(dataE), .o_parity_err(perrE),
    .o_frame_err(ferrE), .o_overflow(ovfE), .o_busy(busyE), .o_fifo_count(cntE)
  );

  uart_rx_param #(.clks_per_bit(CPBS), .parity_mode(2)) dutO (
    .i_clock(clk), .i_reset_n(rstP), .i_rx_uart(rxP), .o_rx_valid(validO),
    .i_rx_ready(rdyP), .o_rx_data(dataO), .o_parity_err(perrO),
    .o_frame_err(ferrO), .o_overflow(ovfO), .o_busy(busyO), .o_fifo_count(cntO)
  );

  uart_rx_param #(.clks_per_bit(CPBS), .stop_bits(2)) dut2 (
    .i_clock(clk), .i_reset_n(rst2), .i_rx_uart(rx2), .o_rx_valid(valid2),
    .i_rx_ready(rdy2), .o_rx_data(data2), .o_parity_err(perr2),
    .o_frame_err(ferr2), .o_overflow(ovf2), .o_busy(busy2), .o_fifo_count(cnt2)
  );

  // Observe the default receiver just after each falling edge, once inputs
  // driven on that edge have settled; a pop happens on the next rising edge.
  always begin
    @(negedge clk);
    #1;
    if (rst0 === 1'b1 && valid0 === 1'b1 && rdy0 === 1'b1)
      popQ0.push_back({data0, perr0, ferr0});
    if (ovf0 === 1'b1)
      ovfCnt0++;
  end

  task automatic drive_line(input int grp, input logic v, input int cycles);
    case (grp)
      0:       rx0 = v;
      1:       rxP = v;
      default: rx2 = v;
    endcase
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input int grp, input int cpb, input logic [7:0] d,
                            input bit hasPar, input logic pbit,
                            input logic s1, input logic s2, input bit twoStop);
    drive_line(grp, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_line(grp, d[i], cpb);
    if (hasPar) drive_line(grp, pbit, cpb);
    drive_line(grp, s1, cpb);
    if (twoStop) drive_line(grp, s2, cpb);
  endtask

  task automatic wait_valid(input int grp, input int maxCycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if ((grp == 0 && valid0 === 1'b1) ||
          (grp == 1 && validE === 1'b1 && validO === 1'b1) ||
          (grp == 2 && valid2 === 1'b1)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b0; rstP = 1'b0; rst2 = 1'b0;
    rx0 = 1'b1; rxP = 1'b1; rx2 = 1'b1;
    rdy0 = 1'b0; rdyP = 1'b0; rdy2 = 1'b0;
    repeat (3) @(negedge clk);
    nCompared++;
    if ({valid0, data0, perr0, ferr0, ovf0, busy0, cnt0} !== 15'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_dut0: got %h expected 0", {valid0, data0, perr0, ferr0, ovf0, busy0, cnt0});
    end
    nCompared++;
    if ({validE, dataE, perrE, ferrE, ovfE, busyE, cntE, validO, dataO, perrO, ferrO, ovfO, busyO, cntO} !== 30'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_parity_pair: got nonzero outputs, expected 0");
    end
    nCompared++;
    if ({valid2, data2, perr2, ferr2, ovf2, busy2, cnt2} !== 15'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_dut2: got %h expected 0", {valid2, data2, perr2, ferr2, ovf2, busy2, cnt2});
    end
    rst0 = 1'b1; rstP = 1'b1; rst2 = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [9:0] got;
    int ovfStart;
    popQ0.delete();
    ovfStart = ovfCnt0;
    rdy0 = 1'b1;
    send_frame(0, CPB0, 8'h14, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(0, CPB0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_line(0, 1'b1, 20);
    nCompared++;
    if (popQ0.size() !== 2) begin
      nMismatched++;
      $display("[TB] FAIL b2b_pop_count: got %0d expected 2", popQ0.size());
    end
    got = (popQ0.size() > 0) ? popQ0[0] : 10'bx;
    nCompared++;
    if (got !== {8'h14, 2'b00}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first: got %h expected %h", got, {8'h14, 2'b00});
    end
    got = (popQ0.size() > 1) ? popQ0[1] : 10'bx;
    nCompared++;
    if (got !== {8'hFF, 2'b00}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_second: got %h expected %h", got, {8'hFF, 2'b00});
    end
    nCompared++;
    if (ovfCnt0 - ovfStart !== 0 || cnt0 !== 3'd0) begin
      nMismatched++;
      $display("[TB] FAIL b2b_ovf_count: got ovf=%0d cnt=%0d expected 0/0", ovfCnt0 - ovfStart, cnt0);
    end
    rdy0 = 1'b0;
  endtask

  task automatic test_parity();
    bit   ok;
    logic pbit, expE;
    for (int k = 0; k < 2; k++) begin
      pbit = (k == 0);
      expE = (k == 1);
      send_frame(1, CPBS, 8'h37, 1'b1, pbit, 1'b1, 1'b1, 1'b0);
      drive_line(1, 1'b1, CPBS);
      wait_valid(1, 4 * CPBS, ok);
      nCompared++;
      if (!ok) begin
        nMismatched++;
        $display("[TB] FAIL parity_valid_timeout: got no entry expected one");
      end
      nCompared++;
      if ({dataE, perrE, ferrE} !== {8'h37, expE, 1'b0}) begin
        nMismatched++;
        $display("[TB] FAIL parity_even p=%0b: got %h expected %h", pbit, {dataE, perrE, ferrE}, {8'h37, expE, 1'b0});
      end
      nCompared++;
      if ({dataO, perrO, ferrO} !== {8'h37, ~expE, 1'b0}) begin
        nMismatched++;
        $display("[TB] FAIL parity_odd p=%0b: got %h expected %h", pbit, {dataO, perrO, ferrO}, {8'h37, ~expE, 1'b0});
      end
      rdyP = 1'b1; @(negedge clk); rdyP = 1'b0; @(negedge clk);
      nCompared++;
      if ({cntE, cntO} !== 6'd0) begin
        nMismatched++;
        $display("[TB] FAIL parity_pop: got %0d/%0d expected 0/0", cntE, cntO);
      end
    end
  endtask

  task automatic test_stop2();
    bit ok;
    send_frame(2, CPBS, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive_line(2, 1'b0, 9 * CPBS);
    nCompared++;
    if (busy2 !== 1'b1 || valid2 !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL stop2_break_busy: got busy=%b valid=%b expected 1/1", busy2, valid2);
    end
    nCompared++;
    if ({data2, perr2, ferr2} !== {8'hA5, 2'b01}) begin
      nMismatched++;
      $display("[TB] FAIL stop2_frame_err: got %h expected %h", {data2, perr2, ferr2}, {8'hA5, 2'b01});
    end
    drive_line(2, 1'b1, 3 * CPBS);
    nCompared++;
    if (busy2 !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL stop2_idle: got busy=%b expected 0", busy2);
    end
    rdy2 = 1'b1; @(negedge clk); rdy2 = 1'b0;
    send_frame(2, CPBS, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drive_line(2, 1'b1, CPBS);
    wait_valid(2, 4 * CPBS, ok);
    nCompared++;
    if (!ok || {data2, perr2, ferr2} !== {8'h5A, 2'b00}) begin
      nMismatched++;
      $display("[TB] FAIL stop2_clean: got valid=%b %h expected 1 %h", ok, {data2, perr2, ferr2}, {8'h5A, 2'b00});
    end
    rdy2 = 1'b1; @(negedge clk); rdy2 = 1'b0; @(negedge clk);
  endtask

  task automatic test_glitch();
    drive_line(0, 1'b0, 50);
    nCompared++;
    if (busy0 !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL glitch_start_busy: got %b expected 1", busy0);
    end
    drive_line(0, 1'b1, 300);
    nCompared++;
    if ({busy0, valid0, cnt0} !== 5'd0) begin
      nMismatched++;
      $display("[TB] FAIL glitch_reject: got busy=%b valid=%b cnt=%0d expected 0/0/0", busy0, valid0, cnt0);
    end
  endtask

  task automatic test_overflow();
    int ovfStart;
    logic [9:0] got;
    popQ0.delete();
    ovfStart = ovfCnt0;
    rdy0 = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(0, CPB0, 8'(v), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (v == 4) begin
        nCompared++;
        if (cnt0 !== 3'd4 || ovfCnt0 - ovfStart !== 0) begin
          nMismatched++;
          $display("[TB] FAIL ovf_fill4: got cnt=%0d ovf=%0d expected 4/0", cnt0, ovfCnt0 - ovfStart);
        end
      end
    end
    drive_line(0, 1'b1, 20);
    nCompared++;
    if (cnt0 !== 3'd4 || ovfCnt0 - ovfStart !== 1) begin
      nMismatched++;
      $display("[TB] FAIL ovf_pulse: got cnt=%0d ovf=%0d expected 4/1", cnt0, ovfCnt0 - ovfStart);
    end
    rdy0 = 1'b1;
    for (int i = 0; i < 40 && cnt0 !== 3'd0; i++) @(negedge clk);
    rdy0 = 1'b0;
    nCompared++;
    if (cnt0 !== 3'd0 || popQ0.size() !== 4) begin
      nMismatched++;
      $display("[TB] FAIL ovf_drain: got cnt=%0d pops=%0d expected 0/4", cnt0, popQ0.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (popQ0.size() > i) ? popQ0[i] : 10'bx;
      nCompared++;
      if (got !== {8'(i + 1), 2'b00}) begin
        nMismatched++;
        $display("[TB] FAIL ovf_order[%0d]: got %h expected %h", i, got, {8'(i + 1), 2'b00});
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    logic [7:0] d = 8'hC3;
    send_frame(0, CPB0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_line(0, 1'b1, 10);
    drive_line(0, 1'b0, CPB0);
    for (int i = 0; i < 3; i++) drive_line(0, d[i], CPB0);
    drive_line(0, d[3], CPB0 / 2);
    rst0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    rx0  = 1'b1;
    nCompared++;
    if ({valid0, data0, perr0, ferr0, ovf0, busy0, cnt0} !== 15'd0) begin
      nMismatched++;
      $display("[TB] FAIL midframe_reset: got %h expected 0", {valid0, data0, perr0, ferr0, ovf0, busy0, cnt0});
    end
    drive_line(0, 1'b1, 3 * CPB0);
    nCompared++;
    if ({valid0, busy0, cnt0} !== 5'd0) begin
      nMismatched++;
      $display("[TB] FAIL midframe_no_entry: got valid=%b busy=%b cnt=%0d expected 0/0/0", valid0, busy0, cnt0);
    end
    send_frame(0, CPB0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive_line(0, 1'b1, 10);
    wait_valid(0, CPB0, ok);
    nCompared++;
    if (!ok || {data0, perr0, ferr0} !== {8'h3C, 2'b00}) begin
      nMismatched++;
      $display("[TB] FAIL midframe_next: got valid=%b %h expected 1 %h", ok, {data0, perr0, ferr0}, {8'h3C, 2'b00});
    end
    rdy0 = 1'b1; @(negedge clk); rdy0 = 1'b0; @(negedge clk);
  endtask

  task automatic test_random();
    bit         ok;
    logic [7:0] d;
    logic       pbit, stopv, expE, expF;
    for (int n = 0; n < 12; n++) begin
      d     = 8'($urandom_range(0, 255));
      pbit  = 1'($urandom_range(0, 1));
      stopv = ($urandom_range(0, 3) != 0);
      expE  = (($countones(d) + int'(pbit)) % 2) != 0;
      expF  = !stopv;
      send_frame(1, CPBS, d, 1'b1, pbit, stopv, 1'b1, 1'b0);
      drive_line(1, 1'b1, 2 * CPBS);
      wait_valid(1, 4 * CPBS, ok);
      nCompared++;
      if (!ok || {dataE, perrE, ferrE} !== {d, expE, expF}) begin
        nMismatched++;
        $display("[TB] FAIL random_even[%0d]: got valid=%b %h expected 1 %h", n, ok, {dataE, perrE, ferrE}, {d, expE, expF});
      end
      nCompared++;
      if (!ok || {dataO, perrO, ferrO} !== {d, ~expE, expF}) begin
        nMismatched++;
        $display("[TB] FAIL random_odd[%0d]: got valid=%b %h expected 1 %h", n, ok, {dataO, perrO, ferrO}, {d, ~expE, expF});
      end
      rdyP = 1'b1; @(negedge clk); rdyP = 1'b0; @(negedge clk);
      nCompared++;
      if ({cntE, cntO, busyE, busyO} !== 8'd0) begin
        nMismatched++;
        $display("[TB] FAIL random_drain[%0d]: got cnt=%0d/%0d busy=%b/%b expected 0", n, cntE, cntO, busyE, busyO);
      end
    end
  endtask

  initial begin
    rst0 = 1'b0; rstP = 1'b0; rst2 = 1'b0;
    rx0 = 1'b1; rxP = 1'b1; rx2 = 1'b1;
    rdy0 = 1'b0; rdyP = 1'b0; rdy2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_parity();
    test_stop2();
    test_glitch();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
